// File: rtl/otg_hpi_cycle_engine.sv
// otg_hpi_cycle_engine: Avalon-MM slave to CY7C67200 HPI bus cycle engine (OTG_HPI_IRQ_EN adds otg_int->irq synchroniser)
module otg_hpi_cycle_engine #(
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  input  logic        otg_int,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RECOVER} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic req, last, accept, is_wr, is_wr_nx, active_nx;
  assign req = chipselect & (read | write);
  assign last = cnt == 8'd0;
  assign accept = (state == IDLE) && req;
  assign is_wr_nx = accept ? write : is_wr;
  assign active_nx = state_nx inside {SETUP, STROBE, HOLD};
  assign waitrequest = req & (state != DONE);
  always_comb begin
    state_nx = state;
    cnt_nx = last ? 8'd0 : cnt - 8'd1;
    case (state)
      IDLE:    if (req) begin state_nx = SETUP; cnt_nx = 8'(SETUP_CYCLES - 1); end
      SETUP:   if (last) begin state_nx = STROBE; cnt_nx = 8'(STROBE_CYCLES - 1); end
      STROBE:  if (last) begin state_nx = HOLD; cnt_nx = 8'(HOLD_CYCLES - 1); end
      HOLD:    if (last) state_nx = DONE;
      DONE:    begin state_nx = RECOVER; cnt_nx = 8'(RECOVERY_CYCLES - 1); end
      RECOVER: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      is_wr        <= 1'b0;
      otg_addr     <= 2'd0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_rst_n    <= 1'b0;
      otg_data_out <= 16'd0;
      otg_data_oe  <= 1'b0;
      readdata     <= 16'd0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      is_wr        <= is_wr_nx;
      otg_rst_n    <= 1'b1;
      otg_addr     <= accept ? address : otg_addr;
      otg_data_out <= (accept && write) ? writedata : otg_data_out;
      otg_cs_n     <= !active_nx;
      otg_rd_n     <= !(state_nx == STROBE && !is_wr_nx);
      otg_wr_n     <= !(state_nx == STROBE && is_wr_nx);
      otg_data_oe  <= active_nx && is_wr_nx;
      readdata     <= (state == STROBE && last && !is_wr) ? otg_data_in : readdata;
    end
  end
`ifdef OTG_HPI_IRQ_EN
  logic [1:0] int_sync;
  always_ff @(posedge clk) int_sync <= reset ? 2'b00 : {int_sync[0], otg_int};
  assign irq = int_sync[1];
`else
  logic unused_otg_int;
  assign unused_otg_int = otg_int;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_otg_hpi_cycle_engine.sv
// tb_otg_hpi_cycle_engine: scoreboard bench for the HPI cycle engine at S=2,T=4,H=1,R=3
module tb_otg_hpi_cycle_engine;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [15:0] writedata = 16'd0, readdata, otg_data_out, otg_data_in = 16'd0;
  logic waitrequest, otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_data_oe;
  logic [1:0] otg_addr;
  logic otg_int = 1'b0, irq;
  int checks = 0, errors = 0;
  logic [15:0] last_rd = 16'd0;
  typedef struct {logic wr; logic [15:0] rdata;} exp_t;
  exp_t sb[$];

  otg_hpi_cycle_engine dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
    .otg_rst_n(otg_rst_n), .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
    .otg_data_in(otg_data_in), .otg_int(otg_int), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic r, input logic w, input logic [1:0] a, input logic [15:0] d,
                      input logic [15:0] din, input int lat, input logic keep);
    int k = 0, cs_lo = 0, rd_lo = 0, wr_lo = 0, oe_hi = 0, bad_a = 0, bad_d = 0;
    exp_t e;
    chipselect = 1'b1; read = r; write = w; address = a; writedata = d; otg_data_in = din;
    sb.push_back('{wr: w, rdata: w ? last_rd : din});
    if (!w) last_rd = din;
    forever begin
      @(negedge clk);
      k++;
      if (!waitrequest || k > 40) break;
      if (!otg_cs_n) begin cs_lo++; if (otg_addr !== a) bad_a++; end
      if (!otg_rd_n) rd_lo++;
      if (!otg_wr_n) wr_lo++;
      if (otg_data_oe) begin oe_hi++; if (otg_data_out !== d) bad_d++; end
    end
    e = sb.pop_front();
    chk("latency", k, lat);
    chk("cs_low", cs_lo, 7);
    chk("rd_low", rd_lo, e.wr ? 0 : 4);
    chk("wr_low", wr_lo, e.wr ? 4 : 0);
    chk("oe_high", oe_hi, e.wr ? 7 : 0);
    chk("addr_bad", bad_a, 0);
    chk("data_bad", bad_d, 0);
    chk("readdata", readdata, e.rdata);
    chk("done_cs", otg_cs_n, 1);
    if (!keep) begin
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cs", otg_cs_n, 1);
    chk("rst_rd", otg_rd_n, 1);
    chk("rst_wr", otg_wr_n, 1);
    chk("rst_chip", otg_rst_n, 0);
    chk("rst_oe", otg_data_oe, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_chip_rel", otg_rst_n, 1);
    chk("idle_wait", waitrequest, 0);
    xfer(1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 8, 1'b0);
    xfer(1'b1, 1'b0, 2'd3, 16'h0000, 16'hBEEF, 8, 1'b0);
    xfer(1'b1, 1'b0, 2'd1, 16'h0000, 16'hCAFE, 8, 1'b1);
    xfer(1'b1, 1'b0, 2'd1, 16'h0000, 16'hCAFE, 12, 1'b0);
    xfer(1'b1, 1'b1, 2'd0, 16'h00A5, 16'h7777, 8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      xfer(!w, w, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 8, 1'b0);
    end
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 2'd1; otg_data_in = 16'h5555;
    repeat (4) @(negedge clk);
    chk("mid_strobe_rd", otg_rd_n, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs", otg_cs_n, 1);
    chk("abort_rd", otg_rd_n, 1);
    chk("abort_wr", otg_wr_n, 1);
    chk("abort_oe", otg_data_oe, 0);
    chk("abort_chip", otg_rst_n, 0);
    chk("abort_wait", waitrequest, 1);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; reset = 1'b0; last_rd = 16'd0;
    @(negedge clk);
    chk("abort_rdata", readdata, 0);
    xfer(1'b0, 1'b1, 2'd2, 16'h4321, 16'h0000, 8, 1'b0);
    otg_int = 1'b1;
    n = 0;
    while (n < 5 && !irq) begin @(negedge clk); n++; end
`ifdef OTG_HPI_IRQ_EN
    chk("irq_rise", irq, 1);
    chk("irq_lat_ok", n >= 2 && n <= 3, 1);
`else
    chk("irq_tied", irq, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
